alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
Multi-cycle control end of the 2-bit-opcode ALU datapath: accepts 16-bit instructions over a valid/ready handshake and decodes them. Reads operands from a private 4-entry register file, drives the ALU's opcode/op1/op2 inputs, captures the ALU result and writes it back. Sits between the instruction source and the combinational ALU in the custom processor.

Parameters:
ALU_WIDTH, 16, datapath/register width; must be >= 8.
NUM_REGS, 4, register-file depth; fixed at 4 by the 2-bit register fields.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
instr_valid  input  1  instruction source has an instruction
instr_ready  output  1  block can accept; high only in IDLE
instr  input  16  [15:14] op, [13:12] rd, [11:10] rs1, [9:8] rs2, [7] imm_sel, [6:0] imm7
alu_opcode  output  2  to ALU: 00 add, 01 sub, 10 and, 11 or
alu_op1  output  ALU_WIDTH  to ALU first operand
alu_op2  output  ALU_WIDTH  to ALU second operand
alu_result  input  ALU_WIDTH  combinational result from ALU
result_valid  output  1  one-cycle pulse: result_data/result_rd valid
result_data  output  ALU_WIDTH  captured ALU result
result_rd  output  2  destination register of result_data
busy  output  1  high in ISSUE or WB

Behaviour:
- Reset: state IDLE. All registers, alu_opcode, alu_op1, alu_op2, result_data, result_rd = 0. result_valid = 0; busy = 0; instr_ready = 1 once reset deasserts.
- FSM states: IDLE -> ISSUE -> WB -> IDLE. No other transitions.
- IDLE: instr_ready = 1. On an edge with instr_valid & instr_ready, the accept edge E0 does all of the following:
  - registers alu_opcode = instr[15:14];
  - registers alu_op1 = reg[rs1];
  - registers alu_op2 = imm_sel ? sign_extend(imm7) : reg[rs2];
  - latches rd;
  - moves to ISSUE.
- ISSUE (1 cycle): ALU inputs are stable and alu_result is combinationally valid. At edge E1: result_data = alu_result, result_rd = rd, state -> WB.
- WB (1 cycle): result_valid = 1. At edge E2: reg[rd] = result_data, state -> IDLE.
- Timing: result_valid is high in the 2nd cycle after E0. Throughput is 1 instruction per 3 cycles. No hazards, because operands are read only in IDLE after the prior write completes.
- alu_opcode, alu_op1 and alu_op2 hold their last values outside ISSUE. result_data and result_rd hold until the next E1.
- Arithmetic: imm7 is sign-extended to ALU_WIDTH. The block does no arithmetic itself; ALU add/sub wrap modulo 2^ALU_WIDTH.
- instr_valid while busy: ignored, not queued. An instruction held valid across busy is accepted exactly once, at the first IDLE edge.
- rs1 == rd or rs2 == rd: legal. The old value is read; the new value is written at E2.
- Reset mid-operation (ISSUE or WB): immediate return to IDLE with all state zeroed. The in-flight instruction is dropped: no result_valid and no register write.

Optional Feature:
- Macro: ALU_ISSUE_RETIRE_CNT_EN.
- When defined:
  - extra output retire_cnt [15:0], reset 0;
  - increments at each E2 edge; wraps 0xFFFF -> 0x0000.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package alu_ctrl_pkg holds:
  - state enum (IDLE, ISSUE, WB);
  - opcode localparams ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11;
  - instruction field bit positions;
  - imm7 width constant.
- Sub-module ctrl_regfile: 4 x ALU_WIDTH, two asynchronous read ports, one synchronous write port, asynchronous active-high reset to 0.

Test Plan:
1. Assert reset mid-stream, then release -> instr_ready=1, busy=0, result_valid=0, all ALU outputs 0, all registers 0.
2. OR r1 = r0 | imm 5 (instr 16'hD085) -> in ISSUE: alu_opcode=11, op1=0, op2=5. Two cycles after accept: result_valid=1, result_data=0x0005, result_rd=1.
3. ADD r2 = r0 + imm -1 (imm7=7'h7F), then ADD r3 = r2 + imm 1 -> op2=0xFFFF and result 0xFFFF; then result 0x0000 (wrap).
4. SUB r1 - r2 register form after steps 2-3 (op=01, rd=0, rs1=1, rs2=2, imm_sel=0) -> op1=0x0005, op2=0xFFFF, result_data=0x0006.
5. Hold instr_valid=1 with the same instruction for 6 cycles -> exactly 2 accepts, 3 cycles apart. instr_ready is low in ISSUE/WB. With the macro defined, retire_cnt increases by 2.
6. Assert reset during ISSUE of AND r1 = r1 & imm 0 -> no result_valid pulse. Afterwards r1 reads 0 and the FSM is in IDLE.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU issue controller.
// Optional retire counter in the top is enabled by defining ALU_ISSUE_RETIRE_CNT_EN.
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWb    = 2'd2
    } state_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // Instruction field bit positions
    localparam int unsigned OP_HI       = 15;
    localparam int unsigned OP_LO       = 14;
    localparam int unsigned RD_HI       = 13;
    localparam int unsigned RD_LO       = 12;
    localparam int unsigned RS1_HI      = 11;
    localparam int unsigned RS1_LO      = 10;
    localparam int unsigned RS2_HI      = 9;
    localparam int unsigned RS2_LO      = 8;
    localparam int unsigned IMM_SEL_BIT = 7;

    localparam int unsigned IMM7_W = 7;

endpackage

// File: rtl/ctrl_regfile.sv
// Private register file of the issue controller: two async read ports, one sync write port.
module ctrl_regfile #(
    parameter int unsigned ALU_WIDTH = 16,
    parameter int unsigned NUM_REGS  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           raddr1,
    output logic [ALU_WIDTH-1:0] rdata1,
    input  logic [1:0]           raddr2,
    output logic [ALU_WIDTH-1:0] rdata2,
    input  logic                 we,
    input  logic [1:0]           waddr,
    input  logic [ALU_WIDTH-1:0] wdata
);

    logic [ALU_WIDTH-1:0] mem_q [NUM_REGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata1 = mem_q[raddr1];
    assign rdata2 = mem_q[raddr2];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Three-state issue controller: decode in IDLE, ALU evaluates in ISSUE, write back in WB.
// Define ALU_ISSUE_RETIRE_CNT_EN to add the 16-bit retire_cnt output.
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned ALU_WIDTH = 16,
    parameter int unsigned NUM_REGS  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [15:0]          instr,
    output logic [1:0]           alu_opcode,
    output logic [ALU_WIDTH-1:0] alu_op1,
    output logic [ALU_WIDTH-1:0] alu_op2,
    input  logic [ALU_WIDTH-1:0] alu_result,
    output logic                 result_valid,
    output logic [ALU_WIDTH-1:0] result_data,
    output logic [1:0]           result_rd,
    output logic                 busy
`ifdef ALU_ISSUE_RETIRE_CNT_EN
    ,
    output logic [15:0]          retire_cnt
`endif
);

    state_e               state_q, state_d;
    logic                 accept;
    logic                 rf_we;
    logic [1:0]           rd_q;
    logic [ALU_WIDTH-1:0] rs1_data, rs2_data;
    logic [ALU_WIDTH-1:0] imm_ext;

    assign accept  = instr_valid & instr_ready;
    assign imm_ext = {{(ALU_WIDTH - IMM7_W){instr[IMM7_W-1]}}, instr[IMM7_W-1:0]};

    ctrl_regfile #(
        .ALU_WIDTH (ALU_WIDTH),
        .NUM_REGS  (NUM_REGS)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .raddr1 (instr[RS1_HI:RS1_LO]),
        .rdata1 (rs1_data),
        .raddr2 (instr[RS2_HI:RS2_LO]),
        .rdata2 (rs2_data),
        .we     (rf_we),
        .waddr  (result_rd),
        .wdata  (result_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StIssue;
            StIssue: state_d = StWb;
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        instr_ready  = (state_q == StIdle);
        busy         = (state_q == StIssue) || (state_q == StWb);
        result_valid = (state_q == StWb);
        rf_we        = (state_q == StWb);
    end

    // ALU inputs and result hold their values between updates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_opcode  <= ALU_ADD;
            alu_op1     <= '0;
            alu_op2     <= '0;
            rd_q        <= '0;
            result_data <= '0;
            result_rd   <= '0;
        end else begin
            if (accept) begin
                alu_opcode <= instr[OP_HI:OP_LO];
                alu_op1    <= rs1_data;
                alu_op2    <= instr[IMM_SEL_BIT] ? imm_ext : rs2_data;
                rd_q       <= instr[RD_HI:RD_LO];
            end
            if (state_q == StIssue) begin
                result_data <= alu_result;
                result_rd   <= rd_q;
            end
        end
    end

`ifdef ALU_ISSUE_RETIRE_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_cnt <= '0;
        end else if (state_q == StWb) begin
            retire_cnt <= retire_cnt + 16'd1;
        end
    end
`endif

endmodule
